// File: rtl/signed_compare_arbiter.sv
// Round-robin arbiter feeding a two-stage compare pipeline: NUM_REQ clients share
// one signed comparator and get tagged lt/eq/gt results on a backpressured port.

module signed_comparator #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = $signed(a) < $signed(b);
  assign eq = (a == b);
  assign gt = $signed(a) > $signed(b);

endmodule

module signed_compare_arbiter #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_lt,
  output logic                     rsp_eq,
  output logic                     rsp_gt
);

  logic             s1_valid;
  logic [ID_W-1:0]  s1_id;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [ID_W-1:0]  last;

  logic               s1_adv;
  logic               s2_adv;
  logic [NUM_REQ-1:0] win;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  logic               found;
  logic               grant;
  logic               cmp_lt;
  logic               cmp_eq;
  logic               cmp_gt;

  assign s2_adv = !rsp_valid || rsp_ready;
  assign s1_adv = !s1_valid || s2_adv;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    win      = '0;
    grant_id = '0;
    cand     = '0;
    found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
    if (found) begin
      win[grant_id] = 1'b1;
    end
  end

  // Reset gates the handshake so nothing is accepted while the pipeline is being cleared.
  assign req_ready = (s1_adv && rst_n) ? win : '0;
  assign grant     = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      last     <= ID_W'(NUM_REQ - 1);
    end else if (s1_adv) begin
      if (grant) begin
        s1_valid <= 1'b1;
        s1_id    <= grant_id;
        s1_a     <= req_a[grant_id*WIDTH +: WIDTH];
        s1_b     <= req_b[grant_id*WIDTH +: WIDTH];
        last     <= grant_id;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  signed_comparator #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a  (s1_a),
    .b  (s1_b),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  // Result fields only reload when S1 holds a real request; a bubble just clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_gt    <= 1'b0;
    end else if (s2_adv) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id <= s1_id;
        rsp_lt <= cmp_lt;
        rsp_eq <= cmp_eq;
        rsp_gt <= cmp_gt;
      end
    end
  end

endmodule

// File: tb/tb_signed_compare_arbiter.sv
// Bench for signed_compare_arbiter: directed scenarios plus a random soak, all
// checked against a queue-based capacity/round-robin model with integer compares.

module tb_signed_compare_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [1:0]               rsp_id;
  logic                     rsp_lt;
  logic                     rsp_eq;
  logic                     rsp_gt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id;
    int a;
    int b;
    bit vis;
  } item_t;

  item_t      q[$];
  int         glog[$];
  int         lastg;
  bit         pend[NUM_REQ];
  logic [7:0] opa[NUM_REQ];
  logic [7:0] opb[NUM_REQ];

  signed_compare_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .rsp_gt    (rsp_gt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int toSigned(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  function automatic logic [7:0] pickOperand();
    logic [7:0] edges [5];
    edges = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  task automatic newReq(input int i, input logic [7:0] a, input logic [7:0] b);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
  endtask

  task automatic newRandReq(input int i);
    logic [7:0] a;
    a = pickOperand();
    newReq(i, a, ($urandom_range(0, 7) == 0) ? a : pickOperand());
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]          = pend[i];
      req_a[i*WIDTH +: WIDTH] = opa[i];
      req_b[i*WIDTH +: WIDTH] = opb[i];
    end
  endtask

  // One clock: drive at the falling edge, check just after, update the model at the rising edge.
  task automatic runCycle(input bit rdy);
    logic [NUM_REQ-1:0] expReady;
    int    gid;
    int    obsId;
    int    j;
    bit    fire;
    bit    allow;
    bit    expValid;
    item_t t;
    rsp_ready = rdy;
    driveInputs();
    #1;
    expValid = (q.size() > 0) && q[0].vis;
    fire     = expValid && rdy;
    allow    = (q.size() < 2) || fire;
    gid      = -1;
    if (allow) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        j = (lastg + k) % NUM_REQ;
        if (pend[j] && gid < 0) gid = j;
      end
    end
    expReady = '0;
    if (gid >= 0) expReady[gid] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
    if (expValid && rsp_valid) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(q[0].id));
      checkOutput("rsp_lt", 32'(rsp_lt), 32'(q[0].a < q[0].b));
      checkOutput("rsp_eq", 32'(rsp_eq), 32'(q[0].a == q[0].b));
      checkOutput("rsp_gt", 32'(rsp_gt), 32'(q[0].a > q[0].b));
      checkOutput("one_flag", 32'(int'(rsp_lt) + int'(rsp_eq) + int'(rsp_gt)), 32'd1);
    end
    obsId = -1;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) obsId = i;
    @(posedge clk);
    if (obsId >= 0) glog.push_back(obsId);
    if (fire) void'(q.pop_front());
    if (q.size() > 0 && !q[0].vis) begin
      t     = q[0];
      t.vis = 1'b1;
      q[0]  = t;
    end
    if (gid >= 0) begin
      t.id  = gid;
      t.a   = toSigned(opa[gid]);
      t.b   = toSigned(opb[gid]);
      t.vis = 1'b0;
      q.push_back(t);
      lastg     = gid;
      pend[gid] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] keep, input bit randomValid, input bit rdy);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i] && (keep[i] || (randomValid && $urandom_range(0, 1) == 1))) newRandReq(i);
    end
    runCycle(rdy);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    driveInputs();
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'd0);
    q.delete();
    glog.delete();
    lastg = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkGrants(input string tag, input int exp[$]);
    checkOutput({tag, "_count"}, 32'(glog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++) begin
      checkOutput(tag, 32'(glog[i]), 32'(exp[i]));
    end
  endtask

  task automatic boundaryPair(input logic [7:0] a, input logic [7:0] b, input logic [2:0] expFlags);
    newReq(0, a, b);
    runCycle(1'b1);
    runCycle(1'b1);
    #1;
    checkOutput("bnd_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bnd_id", 32'(rsp_id), 32'd0);
    checkOutput("bnd_flags", 32'({rsp_lt, rsp_eq, rsp_gt}), 32'(expFlags));
    runCycle(1'b1);
  endtask

  initial begin
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rst_n     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) newRandReq(i);
    @(negedge clk);

    doReset();
    repeat (3) applyStimulus('0, 1'b0, 1'b1);

    boundaryPair(8'h80, 8'h7F, 3'b100);
    boundaryPair(8'hFF, 8'h00, 3'b100);
    boundaryPair(8'h7F, 8'h80, 3'b001);
    boundaryPair(8'h55, 8'h55, 3'b010);

    doReset();
    repeat (6) applyStimulus(4'b1111, 1'b0, 1'b1);
    checkGrants("rr_order", '{0, 1, 2, 3, 0, 1});
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    repeat (3) applyStimulus('0, 1'b0, 1'b1);

    doReset();
    for (int i = 0; i < NUM_REQ; i++) newRandReq(i);
    repeat (4) applyStimulus('0, 1'b0, 1'b0);
    checkGrants("bp_stall", '{0, 1});
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("bp_resume_grant", 32'(glog.size()), 32'd3);
    repeat (6) applyStimulus('0, 1'b0, 1'b1);
    checkGrants("bp_order", '{0, 1, 2, 3});

    doReset();
    repeat (5) applyStimulus(4'b1010, 1'b0, 1'b1);
    newRandReq(2);
    repeat (3) applyStimulus(4'b1010, 1'b0, 1'b1);
    checkGrants("sparse_order", '{1, 3, 1, 3, 1, 2, 3, 1});
    for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
    repeat (3) applyStimulus('0, 1'b0, 1'b1);

    newRandReq(0);
    newRandReq(1);
    repeat (2) applyStimulus('0, 1'b0, 1'b0);
    newRandReq(2);
    newRandReq(3);
    doReset();
    repeat (4) applyStimulus('0, 1'b0, 1'b1);

    for (int c = 0; c < 10000; c++) begin
      applyStimulus('0, 1'b1, ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 12; c++) applyStimulus('0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
